// File: rtl/tsc_leak_decoder_pkg.sv
// Shared constants, FSM encoding and the leak inner-product helper for the
// TSC power-leak receiver.
package tsc_pkg;
    localparam int NUM_RK_DEF    = 8;
    localparam int LEAK_BITS_DEF = 8;
    localparam logic [127:0] TRIG_PATTERN = 128'h00112233_44556677_8899aabb_ccddeeff;

    typedef enum logic {IDLE, COLLECT} fsm_e;

    // XOR-reduce of the AND of the low nbits of state and key; upper bits never matter.
    function automatic logic leak_parity(input logic [127:0] s, input logic [127:0] k,
                                         input int nbits);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 128; i++)
            if (i < nbits) p = p ^ (s[i] & k[i]);
        return p;
    endfunction
endpackage

// File: rtl/tsc_leak_decoder_chan.sv
// One round-key channel: accumulator bit, collection mask bit and the 3-bit
// phase of the Trojan's rotating register.
module tsc_leak_chan
    import tsc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic       p_i,
    input  logic       clr_i,
    output logic       acc_d_o,
    output logic       mask_d_o,
    output logic       dup_o,
    output logic [2:0] rot_o
);
    logic       acc_q;
    logic       mask_q;
    logic [2:0] rot_q;

    // Next-state values are exported so the top can complete a word on the
    // same edge that captures the final key.
    assign acc_d_o  = wr_i ? p_i : acc_q;
    assign mask_d_o = mask_q | wr_i;
    assign dup_o    = wr_i & mask_q;
    assign rot_o    = rot_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= 1'b0;
            mask_q <= 1'b0;
            rot_q  <= 3'd0;
        end else begin
            acc_q  <= acc_d_o;
            mask_q <= clr_i ? 1'b0 : mask_d_o;
            if (wr_i && p_i) rot_q <= rot_q + 3'd1;
        end
    end
endmodule

// File: rtl/tsc_leak_decoder.sv
// Receiver for the TSC power-leak Trojan: arms on the trigger plaintext,
// rebuilds one parity bit per round key and hands out leak words.
module tsc_leak_decoder
    import tsc_pkg::*;
#(
    parameter int NUM_RK    = NUM_RK_DEF,
    parameter int LEAK_BITS = LEAK_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  state_valid,
    input  logic [127:0]          state,
    input  logic                  rk_valid,
    input  logic [3:0]            rk_idx,
    input  logic [127:0]          rk,
    output logic                  armed,
    output logic                  leak_valid,
    input  logic                  leak_ready,
    output logic [NUM_RK-1:0]     leak_word,
    output logic [3*NUM_RK-1:0]   rot_phase,
    output logic                  err_idx,
    output logic                  err_dup,
    output logic                  overflow
);
    fsm_e         fsm_q;
    logic [127:0] state_q;
    logic         collecting, p, idx_bad, word_done, hs;
    logic [NUM_RK-1:0] wr, acc_d, mask_d, dup;

    assign collecting = (fsm_q == COLLECT);
    // Uses state_q from before this edge, even if state_valid is also high.
    assign p          = leak_parity(state_q, rk, LEAK_BITS);
    assign idx_bad    = (rk_idx == 4'd0) || (rk_idx > 4'(NUM_RK));
    assign word_done  = &mask_d;
    assign hs         = leak_valid & leak_ready;

    for (genvar g = 0; g < NUM_RK; g++) begin : g_chan
        assign wr[g] = collecting && rk_valid && (rk_idx == 4'(g + 1));
        tsc_leak_chan u_chan (
            .clk      (clk),
            .rst      (rst),
            .wr_i     (wr[g]),
            .p_i      (p),
            .clr_i    (word_done),
            .acc_d_o  (acc_d[g]),
            .mask_d_o (mask_d[g]),
            .dup_o    (dup[g]),
            .rot_o    (rot_phase[3*g +: 3])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            armed      <= 1'b0;
            leak_valid <= 1'b0;
            leak_word  <= '0;
            err_idx    <= 1'b0;
            err_dup    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (state_valid) state_q <= state;
            case (fsm_q)
                IDLE: if (state_valid && state == TRIG_PATTERN) begin
                    armed <= 1'b1;
                    fsm_q <= COLLECT;
                end
                COLLECT: if (rk_valid && idx_bad) err_idx <= 1'b1;
                default: fsm_q <= IDLE;
            endcase
            if (|dup) err_dup <= 1'b1;
            // A completed word only replaces the held one if it is leaving now.
            if (word_done) begin
                if (!leak_valid || hs) begin
                    leak_word  <= acc_d;
                    leak_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (hs) begin
                leak_valid <= 1'b0;
            end
        end
    end
endmodule
